float_result_monitor: RTL and testbench

FLOAT_RESULT_MONITOR -- requirements
Module: float_result_monitor

---
 rtl/float_result_monitor.sv | 152 +++++++++++++++
 tb/tb_float_result_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_result_monitor.sv
// Checks float_add result/flag consistency, counts flag events and captures
// every accepted set in a first-word fall-through FIFO for later readout.
module float_result_monitor #(
    parameter int DEPTH       = 8,
    parameter int CW          = 16,
    parameter int HALT_ON_ERR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   result,
    input  logic          nan,
    input  logic          overflow,
    input  logic          underflow,
    input  logic          zero,
    input  logic          clear_err,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [36:0]   rd_data,
    output logic [CW-1:0] cnt_total,
    output logic [CW-1:0] cnt_nan,
    output logic [CW-1:0] cnt_ovf,
    output logic [CW-1:0] cnt_unf,
    output logic [CW-1:0] cnt_zero,
    output logic [CW-1:0] cnt_mismatch,
    output logic          err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t        state;
    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;

    logic [7:0]  exp_field;
    logic [22:0] man_field;
    logic        exp_nan;
    logic        exp_inf;
    logic        exp_zero;
    logic        mismatch;
    logic        accept;
    logic        pop;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CW'(1) : c;
    endfunction

    always_comb begin
        exp_field = result[30:23];
        man_field = result[22:0];
        exp_nan   = (exp_field == 8'hFF) && (man_field != 23'd0);
        exp_inf   = (exp_field == 8'hFF) && (man_field == 23'd0);
        exp_zero  = (exp_field == 8'h00) && (man_field == 23'd0);
        mismatch  = (nan != exp_nan) | (overflow != exp_inf) | (zero != exp_zero)
                  | (underflow & (exp_nan | exp_inf));
    end

    assign in_ready = (occupancy != FULL) && (state == RUN);
    assign rd_valid = (occupancy != '0);
    assign accept   = in_valid && in_ready;
    assign pop      = rd_en && rd_valid;

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            rd_data = mem[rd_ptr];
        end
    end

    // Storage carries no reset; stale words are hidden because rd_data is gated by rd_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {mismatch, nan, overflow, underflow, zero, result};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + (AW + 1)'(1);
                2'b01:   occupancy <= occupancy - (AW + 1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_total    <= '0;
            cnt_nan      <= '0;
            cnt_ovf      <= '0;
            cnt_unf      <= '0;
            cnt_zero     <= '0;
            cnt_mismatch <= '0;
        end else if (accept) begin
            cnt_total    <= sat_inc(cnt_total, 1'b1);
            cnt_nan      <= sat_inc(cnt_nan, nan);
            cnt_ovf      <= sat_inc(cnt_ovf, overflow);
            cnt_unf      <= sat_inc(cnt_unf, underflow);
            cnt_zero     <= sat_inc(cnt_zero, zero);
            cnt_mismatch <= sat_inc(cnt_mismatch, mismatch);
        end
    end

    // A fresh mismatch wins over clear_err on the same edge, for both err and state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            err   <= 1'b0;
        end else begin
            if (accept && mismatch) begin
                err <= 1'b1;
            end else if (clear_err) begin
                err <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (accept && mismatch && (HALT_ON_ERR != 0)) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (clear_err) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_float_result_monitor.sv
// Directed and randomized checks of float_result_monitor against a queue-based
// reference model derived from the IEEE-754 classification rules.
module tb_float_result_monitor;

    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   result;
    logic          nan;
    logic          overflow;
    logic          underflow;
    logic          zero;
    logic          clear_err;
    logic          rd_en;
    logic          rd_valid;
    logic [36:0]   rd_data;
    logic [CW-1:0] cnt_total;
    logic [CW-1:0] cnt_nan;
    logic [CW-1:0] cnt_ovf;
    logic [CW-1:0] cnt_unf;
    logic [CW-1:0] cnt_zero;
    logic [CW-1:0] cnt_mismatch;
    logic          err;

    float_result_monitor #(
        .DEPTH      (DEPTH),
        .CW         (CW),
        .HALT_ON_ERR(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .nan         (nan),
        .overflow    (overflow),
        .underflow   (underflow),
        .zero        (zero),
        .clear_err   (clear_err),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .cnt_total   (cnt_total),
        .cnt_nan     (cnt_nan),
        .cnt_ovf     (cnt_ovf),
        .cnt_unf     (cnt_unf),
        .cnt_zero    (cnt_zero),
        .cnt_mismatch(cnt_mismatch),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [36:0] mq[$];
    int  m_total, m_nan, m_ovf, m_unf, m_zero, m_mis;
    bit  m_halt;
    bit  m_err;

    function automatic bit modelMismatch(input logic [31:0] r, input bit n, input bit o,
                                         input bit u, input bit z);
        bit is_nan, is_inf, is_zero;
        is_nan  = (r[30:23] == 8'hFF) && (r[22:0] != 0);
        is_inf  = (r[30:23] == 8'hFF) && (r[22:0] == 0);
        is_zero = (r[30:0] == 0);
        return (n != is_nan) || (o != is_inf) || (z != is_zero) || (u && (is_nan || is_inf));
    endfunction

    function automatic int satAdd(input int c, input bit en);
        return (en && c < CMAX) ? c + 1 : c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        logic [36:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 37'd0;
        check({tag, ".in_ready"}, 64'(in_ready), 64'((mq.size() < DEPTH) && !m_halt));
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(mq.size() > 0));
        check({tag, ".rd_data"}, 64'(rd_data), 64'(exp_data));
        check({tag, ".err"}, 64'(err), 64'(m_err));
        check({tag, ".cnt_total"}, 64'(cnt_total), 64'(m_total));
        check({tag, ".cnt_nan"}, 64'(cnt_nan), 64'(m_nan));
        check({tag, ".cnt_ovf"}, 64'(cnt_ovf), 64'(m_ovf));
        check({tag, ".cnt_unf"}, 64'(cnt_unf), 64'(m_unf));
        check({tag, ".cnt_zero"}, 64'(cnt_zero), 64'(m_zero));
        check({tag, ".cnt_mismatch"}, 64'(cnt_mismatch), 64'(m_mis));
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then samples 1ns later.
    task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] r,
                                 input bit n, input bit o, input bit u, input bit z,
                                 input bit clr, input bit rd, input string tag);
        bit acc, pp, mis;
        reset = rst; in_valid = v; result = r; nan = n; overflow = o;
        underflow = u; zero = z; clear_err = clr; rd_en = rd;
        if (rst) begin
            mq.delete();
            m_total = 0; m_nan = 0; m_ovf = 0; m_unf = 0; m_zero = 0; m_mis = 0;
            m_halt = 0; m_err = 0;
        end else begin
            acc = v && (mq.size() < DEPTH) && !m_halt;
            pp  = rd && (mq.size() > 0);
            mis = modelMismatch(r, n, o, u, z);
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({mis, n, o, u, z, r});
                m_total = satAdd(m_total, 1);
                m_nan   = satAdd(m_nan, n);
                m_ovf   = satAdd(m_ovf, o);
                m_unf   = satAdd(m_unf, u);
                m_zero  = satAdd(m_zero, z);
                m_mis   = satAdd(m_mis, mis);
            end
            if (acc && mis) begin
                m_err  = 1;
                m_halt = 1;
            end else if (clr) begin
                m_err  = 0;
                m_halt = 0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    function automatic logic [31:0] randResult();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r[30:23] = 8'hFF;
            1: r[30:0]  = 31'd0;
            2: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] r;
        bit n, o, u, z, is_nan, is_inf, is_zero;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        applyStimulus(1, 1, 32'h3F800000, 0, 0, 0, 0, 1, 1, "reset1");
        check("reset.in_ready_const", 64'(in_ready), 64'd1);

        // Quiet NaN with a correct nan flag
        applyStimulus(0, 1, 32'h7FC00000, 1, 0, 0, 0, 0, 0, "nan_accept");
        check("nan.rd_data_const", 64'(rd_data), 64'h08_7FC00000);
        check("nan.cnt_nan_const", 64'(cnt_nan), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "nan_pop");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "empty_pop");

        // Zero result without the zero flag halts the monitor
        applyStimulus(0, 1, 32'h00000000, 0, 0, 0, 0, 0, 0, "mismatch");
        check("mismatch.in_ready_const", 64'(in_ready), 64'd0);
        check("mismatch.err_const", 64'(err), 64'd1);
        applyStimulus(0, 1, 32'h00000000, 0, 0, 0, 1, 0, 0, "halted_valid");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "clear_err");
        check("clear.in_ready_const", 64'(in_ready), 64'd1);
        check("clear.err_const", 64'(err), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "drain");

        // Fill to DEPTH, then one more offered set must be refused
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_fill");
        for (int i = 0; i < 9; i++)
            applyStimulus(0, 1, 32'h3F800000 + 32'(i), 0, 0, 0, 0, 0, 0, "fill");
        check("full.cnt_total_const", 64'(cnt_total), 64'd8);
        check("full.in_ready_const", 64'(in_ready), 64'd0);
        applyStimulus(0, 1, 32'h40000000, 0, 0, 0, 0, 0, 1, "full_wr_rd");
        check("full_pop.in_ready_const", 64'(in_ready), 64'd1);
        check("full_pop.cnt_total_const", 64'(cnt_total), 64'd8);

        // Simultaneous push and pop at occupancy 3
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_sim");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 32'h41000000 + 32'(i), 0, 0, 0, 0, 0, 0, "sim_fill");
        applyStimulus(0, 1, 32'hC2000000, 0, 0, 0, 0, 0, 1, "sim_both");
        check("sim.head_const", 64'(rd_data), 64'h00_41000001);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "sim_drain");

        // Reset with stored entries and all other controls active
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 32'h3F000000 + 32'(i), 0, 0, 0, 0, 0, 0, "five");
        applyStimulus(1, 1, 32'h00000000, 0, 0, 0, 0, 1, 1, "reset_five");
        check("reset5.rd_valid_const", 64'(rd_valid), 64'd0);
        check("reset5.cnt_total_const", 64'(cnt_total), 64'd0);

        // Randomized traffic, long enough to saturate the narrow counters
        for (int i = 0; i < 900; i++) begin
            r = randResult();
            is_nan  = (r[30:23] == 8'hFF) && (r[22:0] != 0);
            is_inf  = (r[30:23] == 8'hFF) && (r[22:0] == 0);
            is_zero = (r[30:0] == 0);
            n = is_nan; o = is_inf; z = is_zero;
            u = ($urandom_range(0, 3) == 0) && !is_nan && !is_inf;
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom; o = $urandom; u = $urandom; z = $urandom;
            end
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), r,
                          n, o, u, z, ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 2) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
